// File: rtl/alu_exec_stage.sv
`timescale 1ns/1ps
// alu_exec_stage: execute-stage ALU (AND/OR/ADD/SUB with zero/overflow flags)
// feeding an in-order result buffer with valid/ready on both sides.
// Illegal control codes produce a zero result tagged illegal and are counted.
module alu_exec_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAGW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            overflow,
    output logic            illegal,
    output logic [TAGW-1:0] out_tag,
    output logic [7:0]      illegal_count
);

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110
    } alu_op_e;

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = XLEN + 3 + TAGW;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic [XLEN-1:0] calc_res;
    logic            calc_zero;
    logic            calc_ovf;
    logic            calc_ill;
    logic [EW-1:0]   entry;
    logic [EW-1:0]   head;

    logic [EW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;

    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    // Combinational ALU result and flags for the bundle currently presented
    always_comb begin
        calc_res = '0;
        calc_ovf = 1'b0;
        calc_ill = 1'b0;
        case (alu_ctrl)
            OP_AND: calc_res = op_a & op_b;
            OP_OR:  calc_res = op_a | op_b;
            OP_ADD: begin
                calc_res = sum;
                calc_ovf = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);
            end
            OP_SUB: begin
                calc_res = diff;
                calc_ovf = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff[XLEN-1] != op_a[XLEN-1]);
            end
            default: calc_ill = 1'b1;
        endcase
        calc_zero = !calc_ill && (calc_res == '0);
    end

    assign entry = {calc_res, calc_zero, calc_ovf, calc_ill, in_tag};

    // Ready comes only from registered occupancy, never from out_ready
    assign in_ready  = !rst && !flush && (count < FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head entry is forced to zero when the buffer is empty
    assign head = out_valid ? mem[rptr] : '0;
    assign {result, zero, overflow, illegal, out_tag} = head;

    // Entry storage; only occupied slots are ever observed, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= entry;
        end
    end

    // Pointers and occupancy; flush overrides any concurrent pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Saturating count of accepted illegal operations; survives flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_count <= '0;
        end else if (push && calc_ill && (illegal_count != 8'hFF)) begin
            illegal_count <= illegal_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
`timescale 1ns/1ps
// tb_alu_exec_stage: directed and randomized stimulus checked against a
// queue-based reference model computed with signed integer arithmetic.
module tb_alu_exec_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned TAGW  = 5;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            overflow;
    logic            illegal;
    logic [TAGW-1:0] out_tag;
    logic [7:0]      illegal_count;

    alu_exec_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .overflow(overflow), .illegal(illegal),
        .out_tag(out_tag), .illegal_count(illegal_count)
    );

    typedef struct packed {
        logic [XLEN-1:0] r;
        logic            z;
        logic            ov;
        logic            il;
        logic [TAGW-1:0] t;
    } ent_t;

    ent_t q[$];
    int   icount;
    int   total;
    int   npass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic ent_t model(input logic [3:0] c, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b, input logic [TAGW-1:0] t);
        ent_t   e;
        longint sa;
        longint sb;
        longint sr;
        e    = '0;
        e.t  = t;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        case (c)
            4'b0000: e.r = a & b;
            4'b0001: e.r = a | b;
            4'b0010: begin
                sr   = sa + sb;
                e.r  = 32'(sr);
                e.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            4'b0110: begin
                sr   = sa - sb;
                e.r  = 32'(sr);
                e.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            default: e.il = 1'b1;
        endcase
        e.z = !e.il && (e.r == 0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    endtask

    task automatic check_outputs(input logic fl);
        ent_t h;
        h = '0;
        if (q.size() != 0) h = q[0];
        chk("out_valid", out_valid, q.size() != 0);
        chk("result", result, h.r);
        chk("zero", zero, h.z);
        chk("overflow", overflow, h.ov);
        chk("illegal", illegal, h.il);
        chk("out_tag", out_tag, h.t);
        chk("in_ready", in_ready, !fl && (q.size() < DEPTH));
        chk("illegal_count", illegal_count, icount);
    endtask

    // Called at a falling edge; applies one cycle of inputs and updates the model.
    task automatic cycle(input logic v, input logic [3:0] c, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TAGW-1:0] t,
                         input logic ordy, input logic fl);
        ent_t e;
        logic do_push;
        logic do_pop;
        in_valid = v; alu_ctrl = c; op_a = a; op_b = b; in_tag = t;
        out_ready = ordy; flush = fl;
        #1;
        check_outputs(fl);
        e       = model(c, a, b, t);
        do_push = v && !fl && (q.size() < DEPTH);
        do_pop  = ordy && (q.size() != 0);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(e);
                if (e.il && icount != 255) icount++;
            end
        end
        #1;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 4'b0000, '0, '0, '0, ordy, 1'b0);
    endtask

    function automatic logic [XLEN-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [3:0] rand_ctrl();
        case ($urandom_range(0, 5))
            0: return 4'b0000;
            1: return 4'b0001;
            2: return 4'b0010;
            3: return 4'b0110;
            4: return 4'($urandom_range(0, 15));
            default: return 4'b0010;
        endcase
    endfunction

    task automatic random_run(input int n);
        for (int i = 0; i < n; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_ctrl(), rand_operand(), rand_operand(),
                  TAGW'($urandom()), $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end
    endtask

    initial begin
        total = 0; npass = 0; icount = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_ctrl = '0; op_a = '0; op_b = '0; in_tag = '0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, 32'h0);
        chk("rst_illegal_count", illegal_count, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(1'b0);
        chk("idle_in_ready", in_ready, 1'b1);

        // ADD overflow, then popped one cycle later
        cycle(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h1, 5'd3, 1'b1, 1'b0);
        chk("add_valid", out_valid, 1'b1);
        chk("add_result", result, 32'h8000_0000);
        chk("add_overflow", overflow, 1'b1);
        chk("add_zero", zero, 1'b0);
        chk("add_tag", out_tag, 5'd3);
        idle(1'b1);
        chk("add_popped", out_valid, 1'b0);

        // SUB to zero then AND, back to back
        cycle(1'b1, 4'b0110, 32'd5, 32'd5, 5'd1, 1'b1, 1'b0);
        chk("sub_result", result, 32'h0);
        chk("sub_zero", zero, 1'b1);
        cycle(1'b1, 4'b0000, 32'h0000_F0F0, 32'h0000_0FF0, 5'd2, 1'b1, 1'b0);
        chk("and_result", result, 32'h0000_00F0);
        chk("and_zero", zero, 1'b0);
        chk("and_tag", out_tag, 5'd2);
        idle(1'b1);
        chk("and_popped", out_valid, 1'b0);

        // backpressure: fill, stall third bundle, drain in order
        cycle(1'b1, 4'b0001, 32'd1, 32'd2, 5'd4, 1'b0, 1'b0);
        cycle(1'b1, 4'b0010, 32'd1, 32'd1, 5'd5, 1'b0, 1'b0);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_head", result, 32'd3);
        cycle(1'b1, 4'b0110, 32'd9, 32'd4, 5'd6, 1'b0, 1'b0);
        cycle(1'b1, 4'b0110, 32'd9, 32'd4, 5'd6, 1'b1, 1'b0);
        chk("drain_second", result, 32'd2);
        chk("drain_in_ready", in_ready, 1'b1);
        cycle(1'b1, 4'b0110, 32'd9, 32'd4, 5'd6, 1'b1, 1'b0);
        chk("third_result", result, 32'd5);
        chk("third_tag", out_tag, 5'd6);
        idle(1'b1);
        chk("drained", out_valid, 1'b0);

        // randomized traffic
        random_run(400);

        // asynchronous reset in the middle of traffic
        cycle(1'b1, 4'b0010, 32'd3, 32'd4, 5'd10, 1'b0, 1'b0);
        cycle(1'b1, 4'b0011, 32'd3, 32'd4, 5'd11, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_result", result, 32'h0);
        chk("midrst_out_tag", out_tag, 5'd0);
        chk("midrst_illegal", illegal, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_illegal_count", illegal_count, 8'd0);
        q.delete();
        icount = 0;
        @(negedge clk);
        rst = 1'b0;
        idle(1'b0);

        // illegal codes and counter saturation
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'b0011, $urandom(), $urandom(), TAGW'(i), 1'b1, 1'b0);
            chk("ill_flag", illegal, 1'b1);
            chk("ill_result", result, 32'h0);
            chk("ill_zero", zero, 1'b0);
        end
        chk("ill_count3", illegal_count, 8'd3);
        for (int i = 0; i < 257; i++) begin
            cycle(1'b1, 4'b0011, $urandom(), $urandom(), TAGW'(i), 1'b1, 1'b0);
        end
        idle(1'b1);
        chk("ill_count_sat", illegal_count, 8'd255);

        // flush while full, with concurrent pop and push attempt
        cycle(1'b1, 4'b0010, 32'd10, 32'd20, 5'd7, 1'b0, 1'b0);
        cycle(1'b1, 4'b0001, 32'd8, 32'd1, 5'd8, 1'b0, 1'b0);
        chk("pre_flush_valid", out_valid, 1'b1);
        chk("pre_flush_in_ready", in_ready, 1'b0);
        cycle(1'b1, 4'b0000, 32'hFF, 32'h0F, 5'd9, 1'b1, 1'b1);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_result", result, 32'h0);
        chk("flush_in_ready", in_ready, 1'b1);
        chk("flush_keeps_count", illegal_count, 8'd255);
        idle(1'b1);

        random_run(100);
        idle(1'b1);

        $display("%0d/%0d checks passed", npass, total);
        $finish;
    end

endmodule
